// File: rtl/parking_occupancy_if.sv
// parking_occupancy_if: gate sensor inputs and occupancy/event outputs of the parking counter.
interface parking_occupancy_if #(
    parameter int NUM_GATES = 2,
    parameter int CNT_W     = 8
);
    logic [NUM_GATES-1:0] a;
    logic [NUM_GATES-1:0] b;
    logic [NUM_GATES-1:0] inc_evt;
    logic [NUM_GATES-1:0] dec_evt;
    logic [CNT_W-1:0]     car_count;
    logic                 full;
    logic                 empty;
    logic                 ovf;
    logic                 unf;
    modport master (output a, b, input inc_evt, dec_evt, car_count, full, empty, ovf, unf);
    modport slave  (input a, b, output inc_evt, dec_evt, car_count, full, empty, ovf, unf);
endinterface

// File: rtl/parking_occupancy.sv
// parking_occupancy: per-gate entry/exit sequence FSMs feeding a saturating occupancy counter.
module parking_occupancy #(
    parameter int NUM_GATES = 2,
    parameter int CNT_W     = 8,
    parameter int CAPACITY  = 200
) (
    input logic clk,
    input logic rst,
    parking_occupancy_if.slave bus
);
    localparam int W = CNT_W + 2;
    localparam logic signed [W-1:0] CAP = W'(CAPACITY);

    if (CAPACITY > (1 << CNT_W) - 1 || NUM_GATES < 1 || NUM_GATES > 4) begin : g_bad_param
        $error("parking_occupancy: illegal NUM_GATES/CAPACITY/CNT_W combination");
    end

    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ABORT} state_t;

    logic [NUM_GATES-1:0] w_inc, w_dec;

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        state_t     r_st;
        logic       r_i, r_d;
        logic [1:0] w_p;
        assign w_p      = {bus.a[g], bus.b[g]};
        assign w_inc[g] = r_i;
        assign w_dec[g] = r_d;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_st <= IDLE;
                r_i  <= 1'b0;
                r_d  <= 1'b0;
            end else begin
                r_i <= r_st == EN3 && w_p == 2'b00;
                r_d <= r_st == EX3 && w_p == 2'b00;
                case (r_st)
                    IDLE: r_st <= w_p == 2'b10 ? EN1 : w_p == 2'b01 ? EX1 : w_p == 2'b11 ? ABORT : IDLE;
                    EN1:  r_st <= w_p == 2'b11 ? EN2 : w_p == 2'b00 ? IDLE : w_p == 2'b01 ? ABORT : EN1;
                    EN2:  r_st <= w_p == 2'b01 ? EN3 : w_p == 2'b10 ? EN1 : w_p == 2'b00 ? IDLE : EN2;
                    EN3:  r_st <= w_p == 2'b00 ? IDLE : w_p == 2'b11 ? EN2 : w_p == 2'b10 ? ABORT : EN3;
                    EX1:  r_st <= w_p == 2'b11 ? EX2 : w_p == 2'b00 ? IDLE : w_p == 2'b10 ? ABORT : EX1;
                    EX2:  r_st <= w_p == 2'b10 ? EX3 : w_p == 2'b01 ? EX1 : w_p == 2'b00 ? IDLE : EX2;
                    EX3:  r_st <= w_p == 2'b00 ? IDLE : w_p == 2'b11 ? EX2 : w_p == 2'b01 ? ABORT : EX3;
                    default: r_st <= w_p == 2'b00 ? IDLE : ABORT;
                endcase
            end
        end
    end

    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf, r_unf;
    logic signed [W-1:0] w_net, w_sum;

    always_comb begin
        w_net = '0;
        for (int k = 0; k < NUM_GATES; k++) w_net = w_net + W'(w_inc[k]) - W'(w_dec[k]);
        w_sum = $signed({2'b00, r_cnt}) + w_net;
    end

    // Clip in the wide signed domain so the narrow counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_sum > CAP;
            r_unf <= w_sum[W-1];
            r_cnt <= w_sum[W-1] ? '0 : w_sum > CAP ? CNT_W'(CAPACITY) : w_sum[CNT_W-1:0];
        end
    end

    assign bus.inc_evt   = w_inc;
    assign bus.dec_evt   = w_dec;
    assign bus.car_count = r_cnt;
    assign bus.ovf       = r_ovf;
    assign bus.unf       = r_unf;
    assign bus.full      = r_cnt == CNT_W'(CAPACITY);
    assign bus.empty     = r_cnt == '0;
endmodule

// File: tb/tb_parking_occupancy.sv
// tb_parking_occupancy: directed gate sequences with a scoreboard checking events, count and clip flags.
module tb_parking_occupancy;
    localparam int CAP = 200;
    localparam logic [7:0] ENT = 8'b10_11_01_00;
    localparam logic [7:0] EXT = 8'b01_11_10_00;
    localparam logic [7:0] IDL = 8'b00_00_00_00;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    parking_occupancy_if #(.NUM_GATES(2), .CNT_W(8)) bus ();
    parking_occupancy #(.NUM_GATES(2), .CNT_W(8), .CAPACITY(CAP)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0] inc;
        logic [1:0] dec;
        logic [7:0] cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errs = 0;
    int   checks = 0;
    int   m_cnt = 0;
    logic pend = 0;
    logic [7:0] prev = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic exp_evt(input logic [1:0] inc, input logic [1:0] dec);
        exp_t x;
        int   s;
        s = m_cnt + $countones(inc) - $countones(dec);
        x.inc = inc;
        x.dec = dec;
        x.ovf = s > CAP;
        x.unf = s < 0;
        m_cnt = s > CAP ? CAP : s < 0 ? 0 : s;
        x.cnt = 8'(m_cnt);
        q.push_back(x);
    endtask

    task automatic drive(input logic [1:0] g0, input logic [1:0] g1);
        @(negedge clk);
        bus.a = {g1[1], g0[1]};
        bus.b = {g1[0], g0[0]};
    endtask

    task automatic run4(input logic [7:0] x0, input logic [7:0] x1);
        for (int k = 0; k < 4; k++) drive(x0[7-2*k -: 2], x1[7-2*k -: 2]);
    endtask

    always @(posedge clk) begin
        #2;
        if (rst) begin
            pend = 0;
            prev = 0;
        end else begin
            if (pend) begin
                chk("count", bus.car_count, e.cnt);
                chk("ovf", bus.ovf, e.ovf);
                chk("unf", bus.unf, e.unf);
                chk("full", bus.full, e.cnt == CAP);
                chk("empty", bus.empty, e.cnt == 0);
            end else begin
                chk("idle_ovf", bus.ovf, 0);
                chk("idle_unf", bus.unf, 0);
                chk("hold_count", bus.car_count, prev);
            end
            prev = bus.car_count;
            pend = 0;
            if (bus.inc_evt != 0 || bus.dec_evt != 0) begin
                if (q.size() == 0) chk("spurious_evt", {bus.inc_evt, bus.dec_evt}, 0);
                else begin
                    e = q.pop_front();
                    chk("inc_evt", bus.inc_evt, e.inc);
                    chk("dec_evt", bus.dec_evt, e.dec);
                    pend = 1;
                end
            end
        end
    end

    initial begin
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", bus.car_count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_evt", {bus.inc_evt, bus.dec_evt, bus.ovf, bus.unf}, 0);
        rst = 0;
        exp_evt(2'b01, 2'b00); run4(ENT, IDL);
        exp_evt(2'b10, 2'b00); run4(IDL, ENT);
        exp_evt(2'b01, 2'b00); run4(ENT, IDL);
        drive(2'b10, 2'b00); drive(2'b11, 2'b00); drive(2'b01, 2'b00); drive(2'b01, 2'b00);
        chk("pre_rst_count", bus.car_count, 3);
        @(negedge clk);
        rst = 1;
        bus.a = '0;
        bus.b = '0;
        @(negedge clk);
        rst = 0;
        m_cnt = 0;
        chk("mid_rst_count", bus.car_count, 0);
        chk("mid_rst_empty", bus.empty, 1);
        repeat (3) drive(2'b00, 2'b00);
        chk("post_rst_count", bus.car_count, 0);
        exp_evt(2'b00, 2'b01); run4(EXT, IDL);
        exp_evt(2'b11, 2'b00); run4(ENT, ENT);
        exp_evt(2'b11, 2'b00); run4(ENT, ENT);
        exp_evt(2'b01, 2'b00); run4(ENT, IDL);
        exp_evt(2'b00, 2'b10); run4(IDL, EXT);
        run4(8'b10_11_10_00, IDL);
        exp_evt(2'b11, 2'b00); run4(ENT, ENT);
        exp_evt(2'b10, 2'b00); run4(IDL, ENT);
        exp_evt(2'b01, 2'b10); run4(ENT, EXT);
        drive(2'b10, 2'b00); drive(2'b01, 2'b00);
        drive(2'b10, 2'b00); drive(2'b11, 2'b00); drive(2'b01, 2'b00); drive(2'b00, 2'b00);
        exp_evt(2'b01, 2'b00); run4(ENT, IDL);
        exp_evt(2'b01, 2'b00); run4(ENT, IDL);
        repeat (95) begin
            exp_evt(2'b11, 2'b00); run4(ENT, ENT);
        end
        exp_evt(2'b11, 2'b00); run4(ENT, ENT);
        exp_evt(2'b01, 2'b00); run4(ENT, IDL);
        repeat (4) drive(2'b00, 2'b00);
        chk("final_count", bus.car_count, CAP);
        chk("final_full", bus.full, 1);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/parking_occupancy.md
PARKING_OCCUPANCY -- requirements
Module: parking_occupancy

Interface
REQ-001 Parameter NUM_GATES, default 2, SHALL set the number of independent entry/exit gates, legal range 1..4.
REQ-002 Parameter CNT_W, default 8, SHALL set the occupancy counter width.
REQ-003 Parameter CAPACITY, default 200, SHALL set the maximum occupancy, with CAPACITY <= 2^CNT_W - 1; violating this SHALL be a elaboration-time error.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 a  input  NUM_GATES  SHALL carry the outer sensor per gate, 1 = beam blocked.
REQ-007 b  input  NUM_GATES  SHALL carry the inner sensor per gate, 1 = beam blocked.
REQ-008 car_count  output  CNT_W  SHALL be the registered current occupancy.
REQ-009 full  output  1  SHALL be high when car_count == CAPACITY.
REQ-010 empty  output  1  SHALL be high when car_count == 0.
REQ-011 inc_evt  output  NUM_GATES  SHALL carry a one-cycle pulse per gate on each completed entry.
REQ-012 dec_evt  output  NUM_GATES  SHALL carry a one-cycle pulse per gate on each completed exit.
REQ-013 ovf  output  1  SHALL carry a one-cycle pulse when an update is clipped at CAPACITY.
REQ-014 unf  output  1  SHALL carry a one-cycle pulse when an update is clipped at 0.

Function
REQ-015 Each gate SHALL have its own FSM, sampling {a[i],b[i]} on every clock edge; no input synchronisation is required (inputs are synchronous to clk).
REQ-016 FSM states SHALL be IDLE, EN1, EN2, EN3, EX1, EX2, EX3 and ABORT.
REQ-017 Entry path: IDLE -10-> EN1 -11-> EN2 -01-> EN3 -00-> IDLE, asserting inc_evt[i] on the final transition.
REQ-018 Exit path: IDLE -01-> EX1 -11-> EX2 -10-> EX3 -00-> IDLE, asserting dec_evt[i] on the final transition.
REQ-019 Backing up one step (EN2 -10-> EN1, EN3 -11-> EN2, EX2 -01-> EX1, EX3 -11-> EX2) SHALL be legal and produce no event.
REQ-020 An unchanged sensor pattern SHALL hold the current state.
REQ-021 Pattern 00 in EN1/EN2/EX1/EX2 SHALL return the FSM to IDLE with no event.
REQ-022 Any other transition SHALL go to ABORT; ABORT SHALL stay until 00 is sampled, then go to IDLE with no event.
REQ-023 IDLE with 11 SHALL go to ABORT.
REQ-024 inc_evt/dec_evt SHALL be registered: high for exactly the cycle after the edge that sampled the completing 00.
REQ-025 car_count SHALL update on the edge following the event pulse (two edges after the completing sample).
REQ-026 Per update, net = popcount(inc_evt) - popcount(dec_evt); simultaneous entries and exits on different gates SHALL net out in a single update.
REQ-027 If car_count + net > CAPACITY, car_count SHALL become CAPACITY and ovf SHALL pulse in the same cycle as the update.
REQ-028 If car_count + net < 0, car_count SHALL become 0 and unf SHALL pulse in the same cycle as the update.
REQ-029 Intermediate arithmetic SHALL be signed and at least CNT_W+2 bits wide; no wrap-around SHALL ever occur.
REQ-030 full and empty SHALL be combinational decodes of registered car_count.

Reset
REQ-031 With rst high at a rising edge: all FSMs SHALL go to IDLE; car_count, inc_evt, dec_evt, ovf and unf SHALL become 0; empty SHALL be 1 and full SHALL be 0.
REQ-032 Reset SHALL override any in-flight sequence or pending update; a sequence partially seen before reset SHALL produce no event afterwards.

Verification
REQ-033 Gate 0 samples 00,10,11,01,00 -> inc_evt[0] pulses one cycle; car_count goes 0 to 1 one cycle later; empty falls.
REQ-034 Gate 1 exit 01,11,10,00 from count 5 -> dec_evt[1] pulses; count 4. Gate 0 sequence 10,11,10,00 -> no event.
REQ-035 Same cycle: entry completes on gate 0 and exit completes on gate 1 at count 7 -> both pulses; count stays 7; no ovf/unf.
REQ-036 Count at CAPACITY-1, both gates complete entries in the same cycle -> count = CAPACITY, full = 1, ovf pulses once. Exit at count 0 -> count stays 0, unf pulses.
REQ-037 Gate 0 samples 10 then 01 -> ABORT; a subsequent 10,11,01 while in ABORT produces no event until 00 is sampled, then a full entry counts normally.
REQ-038 rst asserted while gate 0 is in EN3 at count 3 -> count 0, no inc_evt after reset even if 00 follows.
